// File: rtl/br_update_queue_pkg.sv
// Shared widths, queue depth default and the buffered-entry layout for the
// branch predictor update queue.
package br_update_queue_pkg;

    localparam int RV32_PC_WIDTH = 32;
    localparam int GSH_GHR_WIDTH = 8;
    localparam int BRQ_DEPTH     = 4;

    typedef struct packed {
        logic [RV32_PC_WIDTH-1:0] pc;
        logic [GSH_GHR_WIDTH-1:0] ghr;
        logic [RV32_PC_WIDTH-1:0] jmpaddr;
        logic                     jmpcond;
    } brq_entry_t;

endpackage

// File: rtl/br_update_queue_if.sv
// Commit-side and predictor-update-side signals of the branch update queue.
//
// Handshake: o_com_rdy comes from registered state only. A commit pair is
// taken at a rising edge when i_com_vld_1 && o_com_rdy; slot 2 rides along
// only if i_com_vld_2 is also set. While o_com_rdy is low the producer holds
// its inputs. o_upd_vld is a one-cycle strobe with no back-pressure.
interface br_update_queue_if;
    import br_update_queue_pkg::*;

    logic                     i_com_vld_1;
    logic                     i_com_vld_2;
    logic [RV32_PC_WIDTH-1:0] i_com_pc_1;
    logic [RV32_PC_WIDTH-1:0] i_com_pc_2;
    logic [GSH_GHR_WIDTH-1:0] i_com_ghr_1;
    logic [GSH_GHR_WIDTH-1:0] i_com_ghr_2;
    logic [RV32_PC_WIDTH-1:0] i_com_jmpaddr_1;
    logic [RV32_PC_WIDTH-1:0] i_com_jmpaddr_2;
    logic                     i_com_jmpcond_1;
    logic                     i_com_jmpcond_2;
    logic                     o_com_rdy;
    logic                     o_upd_vld;
    logic [RV32_PC_WIDTH-1:0] o_upd_pc;
    logic [GSH_GHR_WIDTH-1:0] o_upd_ghr;
    logic [RV32_PC_WIDTH-1:0] o_upd_jmpaddr;
    logic                     o_upd_jmpcond;
    logic                     o_empty;

    modport master (
        output i_com_vld_1, i_com_vld_2, i_com_pc_1, i_com_pc_2,
               i_com_ghr_1, i_com_ghr_2, i_com_jmpaddr_1, i_com_jmpaddr_2,
               i_com_jmpcond_1, i_com_jmpcond_2,
        input  o_com_rdy, o_upd_vld, o_upd_pc, o_upd_ghr, o_upd_jmpaddr,
               o_upd_jmpcond, o_empty
    );

    modport slave (
        input  i_com_vld_1, i_com_vld_2, i_com_pc_1, i_com_pc_2,
               i_com_ghr_1, i_com_ghr_2, i_com_jmpaddr_1, i_com_jmpaddr_2,
               i_com_jmpcond_1, i_com_jmpcond_2,
        output o_com_rdy, o_upd_vld, o_upd_pc, o_upd_ghr, o_upd_jmpaddr,
               o_upd_jmpcond, o_empty
    );

endinterface

// File: rtl/br_update_queue.sv
// Serialises up to two committed branches per cycle onto the predictor's
// single update port, oldest first, through a small circular buffer.
module br_update_queue
    import br_update_queue_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    br_update_queue_if.slave  bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [CNT_W-1:0] count_q, count_d;
    brq_entry_t       mem_q [DEPTH];
    brq_entry_t       mem_d [DEPTH];
    brq_entry_t       upd_q, upd_d;
    logic             upd_vld_q, upd_vld_d;
    logic             com_rdy;
    logic             enq_1;
    logic             enq_2;
    logic             pop;
    brq_entry_t       slot_1;
    brq_entry_t       slot_2;

    // Ready needs room for a full pair, so a single-slot gap never admits a pair.
    always_comb begin
        com_rdy   = (count_q <= CNT_W'(DEPTH - 2));
        enq_1     = com_rdy & bus.i_com_vld_1;
        enq_2     = enq_1 & bus.i_com_vld_2;
        pop       = (count_q != '0);
        wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
        slot_1    = '{pc: bus.i_com_pc_1, ghr: bus.i_com_ghr_1,
                      jmpaddr: bus.i_com_jmpaddr_1, jmpcond: bus.i_com_jmpcond_1};
        slot_2    = '{pc: bus.i_com_pc_2, ghr: bus.i_com_ghr_2,
                      jmpaddr: bus.i_com_jmpaddr_2, jmpcond: bus.i_com_jmpcond_2};
    end

    always_comb begin
        count_d  = count_q + CNT_W'(enq_1) + CNT_W'(enq_2) - CNT_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(enq_1) + PTR_W'(enq_2);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (enq_1) begin
            mem_d[wr_ptr_q] = slot_1;
        end
        if (enq_2) begin
            mem_d[wr_ptr_p1] = slot_2;
        end
    end

    // Payload holds its last value when nothing is popped.
    always_comb begin
        upd_vld_d = pop;
        upd_d     = pop ? mem_q[rd_ptr_q] : upd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            upd_vld_q <= 1'b0;
            upd_q     <= '0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            upd_vld_q <= upd_vld_d;
            upd_q     <= upd_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.o_com_rdy     = com_rdy;
    assign bus.o_upd_vld     = upd_vld_q;
    assign bus.o_upd_pc      = upd_q.pc;
    assign bus.o_upd_ghr     = upd_q.ghr;
    assign bus.o_upd_jmpaddr = upd_q.jmpaddr;
    assign bus.o_upd_jmpcond = upd_q.jmpcond;
    assign bus.o_empty       = (count_q == '0) && !upd_vld_q;

endmodule

// File: tb/tb_br_update_queue.sv
// Directed bench for br_update_queue: a vector table for single-cycle
// behaviour plus sequences for back-pressure, reset mid-drain and wrap-around.
module tb_br_update_queue;
    import br_update_queue_pkg::*;

    typedef struct {
        logic        v1, v2;
        logic [31:0] pc1, pc2;
        logic        jc1, jc2;
        logic        e_rdy, e_vld, e_empty;
        logic [31:0] e_pc;
        logic        e_jc;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   n_out;
    logic [32:0] exp_q[$];
    vec_t vecs[15];

    br_update_queue_if bif();

    br_update_queue #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [GSH_GHR_WIDTH-1:0] mk_ghr(logic [31:0] pc);
        return GSH_GHR_WIDTH'(pc[9:2] ^ 8'h5a);
    endfunction

    function automatic logic [31:0] mk_tgt(logic [31:0] pc);
        return pc + 32'h40;
    endfunction

    function automatic vec_t mk(logic v1, logic v2, logic [31:0] pc1, logic [31:0] pc2,
                                logic jc1, logic jc2, logic e_rdy, logic e_vld,
                                logic e_empty, logic [31:0] e_pc, logic e_jc);
        vec_t v;
        v.v1 = v1; v.v2 = v2; v.pc1 = pc1; v.pc2 = pc2; v.jc1 = jc1; v.jc2 = jc2;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_empty = e_empty; v.e_pc = e_pc; v.e_jc = e_jc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v1, input logic v2, input logic [31:0] pc1,
                         input logic [31:0] pc2, input logic jc1, input logic jc2);
        bif.i_com_vld_1     = v1;
        bif.i_com_vld_2     = v2;
        bif.i_com_pc_1      = pc1;
        bif.i_com_pc_2      = pc2;
        bif.i_com_ghr_1     = mk_ghr(pc1);
        bif.i_com_ghr_2     = mk_ghr(pc2);
        bif.i_com_jmpaddr_1 = mk_tgt(pc1);
        bif.i_com_jmpaddr_2 = mk_tgt(pc2);
        bif.i_com_jmpcond_1 = jc1;
        bif.i_com_jmpcond_2 = jc2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_payload(input string tag, input logic [31:0] pc, input logic jc);
        chk({tag, "_pc"}, bif.o_upd_pc, pc);
        chk({tag, "_jc"}, 32'(bif.o_upd_jmpcond), 32'(jc));
        chk({tag, "_ghr"}, 32'(bif.o_upd_ghr), (pc == 32'h0) ? 32'h0 : 32'(mk_ghr(pc)));
        chk({tag, "_tgt"}, bif.o_upd_jmpaddr, (pc == 32'h0) ? 32'h0 : mk_tgt(pc));
    endtask

    // Advance one cycle and match any update strobe against the expected queue.
    task automatic tick_mon();
        logic [32:0] e;
        tick();
        if (bif.o_upd_vld) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("mon_unexpected_upd", bif.o_upd_pc, 32'hffff_ffff);
            end else begin
                e = exp_q.pop_front();
                check_payload("mon", e[31:0], e[32]);
            end
        end
    endtask

    initial begin
        int k, acc, saw_low;
        checks   = 0;
        failures = 0;
        n_out    = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset state
        tick();
        tick();
        chk("rst_rdy", 32'(bif.o_com_rdy), 32'd1);
        chk("rst_vld", 32'(bif.o_upd_vld), 32'd0);
        chk("rst_empty", 32'(bif.o_empty), 32'd1);
        check_payload("rst", 32'h0, 1'b0);
        rst_n = 1'b1;

        vecs[0]  = mk(1'b1, 1'b0, 32'h100, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 1'b1);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1);
        vecs[3]  = mk(1'b1, 1'b1, 32'h200, 32'h204, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h204, 1'b1);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h204, 1'b1);
        vecs[7]  = mk(1'b0, 1'b1, 32'h0,   32'h300, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h204, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h204, 1'b1);
        vecs[9]  = mk(1'b1, 1'b1, 32'h400, 32'h404, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h204, 1'b1);
        vecs[10] = mk(1'b1, 1'b1, 32'h408, 32'h40c, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h400, 1'b1);
        vecs[11] = mk(1'b1, 1'b1, 32'h500, 32'h504, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h404, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h408, 1'b1);
        vecs[13] = mk(1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40c, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40c, 1'b0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].v1, vecs[i].v2, vecs[i].pc1, vecs[i].pc2, vecs[i].jc1, vecs[i].jc2);
            tick();
            chk($sformatf("vec%0d_rdy", i), 32'(bif.o_com_rdy), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_vld", i), 32'(bif.o_upd_vld), 32'(vecs[i].e_vld));
            chk($sformatf("vec%0d_empty", i), 32'(bif.o_empty), 32'(vecs[i].e_empty));
            check_payload($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_jc);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Sustained pairs: producer holds a pair until it is accepted
        k = 0; acc = 0; saw_low = 0;
        for (int c = 0; c < 10; c++) begin
            logic took;
            drive(1'b1, 1'b1, 32'h1000 + 32'(8 * k), 32'h1004 + 32'(8 * k), k[0], ~k[0]);
            took = bif.o_com_rdy;
            if (took) begin
                exp_q.push_back({k[0], 32'h1000 + 32'(8 * k)});
                exp_q.push_back({~k[0], 32'h1004 + 32'(8 * k)});
            end else begin
                saw_low = 1;
            end
            tick_mon();
            if (took) begin
                k++;
                acc++;
            end
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick_mon();
        chk("pairs_accepted", 32'(acc), 32'd6);
        chk("pairs_rdy_low_seen", 32'(saw_low), 32'd1);
        chk("pairs_drained", 32'(exp_q.size()), 32'd0);
        tick_mon();
        chk("pairs_empty", 32'(bif.o_empty), 32'd1);

        // Reset while three entries are buffered and one is on the output
        drive(1'b1, 1'b1, 32'h600, 32'h604, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h608, 32'h60c, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("mid_vld", 32'(bif.o_upd_vld), 32'd1);
        chk("mid_pc", bif.o_upd_pc, 32'h600);
        chk("mid_rdy", 32'(bif.o_com_rdy), 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(bif.o_upd_vld), 32'd0);
        chk("arst_empty", 32'(bif.o_empty), 32'd1);
        chk("arst_rdy", 32'(bif.o_com_rdy), 32'd1);
        chk("arst_pc", bif.o_upd_pc, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("post_rst%0d_vld", c), 32'(bif.o_upd_vld), 32'd0);
            chk($sformatf("post_rst%0d_empty", c), 32'(bif.o_empty), 32'd1);
        end

        // Wrap-around: 20 singles with irregular gaps
        n_out = 0;
        for (int i = 0; i < 20; i++) begin
            for (int g = 0; g < (i * 7) % 4; g++) tick_mon();
            drive(1'b1, 1'b0, 32'h2000 + 32'(4 * i), 32'h0, i[0], 1'b0);
            chk($sformatf("wrap%0d_rdy", i), 32'(bif.o_com_rdy), 32'd1);
            exp_q.push_back({i[0], 32'h2000 + 32'(4 * i)});
            tick_mon();
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        end
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick_mon();
        chk("wrap_drained", 32'(exp_q.size()), 32'd0);
        chk("wrap_count", 32'(n_out), 32'd20);
        tick();
        chk("wrap_empty", 32'(bif.o_empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/br_update_queue.md
BR_UPDATE_QUEUE -- requirements
Module: br_update_queue

Interface
REQ-001 DEPTH, default 4, number of buffered predictor updates; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_com_vld_1  input  1  older committed branch valid this cycle.
REQ-005 i_com_vld_2  input  1  younger committed branch valid this cycle; legal only with i_com_vld_1.
REQ-006 i_com_pc_1 / i_com_pc_2  input  `RV32_PC_WIDTH  branch source PC, slot 1 / slot 2.
REQ-007 i_com_ghr_1 / i_com_ghr_2  input  `GSH_GHR_WIDTH  GHR snapshot taken at prediction, slot 1 / slot 2.
REQ-008 i_com_jmpaddr_1 / i_com_jmpaddr_2  input  `RV32_PC_WIDTH  resolved target, slot 1 / slot 2.
REQ-009 i_com_jmpcond_1 / i_com_jmpcond_2  input  1  resolved taken flag, slot 1 / slot 2.
REQ-010 o_com_rdy  output  1  queue accepts a commit pair this cycle.
REQ-011 o_upd_vld  output  1  drives the predictor's single update strobe.
REQ-012 o_upd_pc, o_upd_ghr, o_upd_jmpaddr  output  `RV32_PC_WIDTH / `GSH_GHR_WIDTH / `RV32_PC_WIDTH  update payload.
REQ-013 o_upd_jmpcond  output  1  update taken flag.
REQ-014 o_empty  output  1  no entry buffered and no update on the output.

Function
REQ-015 Block SHALL serialise up to two committed branches per cycle onto the predictor's one-per-cycle BTB/PHT update port, preserving program order.
REQ-016 o_com_rdy SHALL equal (free entries >= 2), decoded from registered count only; no combinational path from any input.
REQ-017 When o_com_rdy=1, slot 1 SHALL be written at wr_ptr and slot 2 at wr_ptr+1 (mod DEPTH); enqueue count = vld_1 + (vld_1 & vld_2).
REQ-018 When o_com_rdy=0, all i_com_* inputs SHALL be ignored; the producer holds them.
REQ-019 i_com_vld_2 without i_com_vld_1 SHALL be ignored (nothing enqueued).
REQ-020 Each cycle with count > 0, the head entry SHALL be popped into the output register; o_upd_vld=1 for exactly that next cycle; otherwise o_upd_vld=0 and payload holds its last value.
REQ-021 Latency: a lone entry accepted at edge t into an empty queue SHALL appear on o_upd_* during the cycle after edge t+1; slot 2 of a pair appears one cycle after slot 1.
REQ-022 Simultaneous enqueue and pop SHALL yield count_next = count + n_enq - 1; pointers SHALL wrap modulo DEPTH.
REQ-023 Count SHALL never exceed DEPTH; sustained pairs SHALL throttle o_com_rdy to no more than one accepted pair per two cycles.
REQ-024 Each entry SHALL be written to the predictor exactly once; duplicate PCs are not merged.
REQ-025 o_empty SHALL be 1 iff count = 0 and o_upd_vld = 0.

Reset
REQ-026 rst_n low SHALL immediately clear count, rd_ptr, wr_ptr and o_upd_vld; o_com_rdy=1 and o_empty=1 while in reset.
REQ-027 Payload outputs SHALL reset to 0; storage array is not reset.
REQ-028 Reset mid-drain SHALL discard all buffered entries; no o_upd_vld pulse in the first cycle after reset release.

Structure
REQ-029 `RV32_PC_WIDTH and `GSH_GHR_WIDTH SHALL come from constants.vh; a new `BRQ_DEPTH default SHALL be added there.
REQ-030 Storage SHALL be a flat register array of entries {pc, ghr, jmpaddr, jmpcond}; no sub-module.
REQ-031 The output port pins SHALL connect directly to the predictor's i_com_br / i_com_pc / i_com_ghr / i_com_jmpaddr / i_com_jmpcond.

Verification
REQ-032 Single commit PC=0x100, jmpcond=1 into empty queue -> o_upd_vld high for one cycle, 2 edges later, pc=0x100.
REQ-033 Pair PC=0x200/0x204 in one cycle -> updates in two consecutive cycles, 0x200 then 0x204.
REQ-034 Pairs every cycle for 10 cycles, DEPTH=4 -> o_com_rdy toggles, count never >4, all accepted PCs emitted in order, no loss or duplication.
REQ-035 vld_2=1 with vld_1=0 -> no enqueue, o_empty stays 1.
REQ-036 Fill to 3 entries, assert rst_n=0 mid-drain -> o_upd_vld=0 immediately, o_empty=1, o_com_rdy=1; after release no stale update.
REQ-037 Wrap-around: 20 singles spaced irregularly -> pointers wrap, output order matches input order.
